// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   W_DEFAULT : default operand width
//   state_e   : FSM state encoding (IDLE, CALC, DONE)
//   cnt_width : width of the iteration counter, enough to hold the value W
package div_pkg;

    localparam int unsigned W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_seq8_if.sv
// Operand/result bus of the sequential divider.
//   E, start, A, B      : driven by the requester (master)
//   Q, R, DZ, busy, done: driven by the divider (slave)
interface div_seq8_if
    import div_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic         E;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         DZ;
    logic         busy;
    logic         done;

    modport master (output E, start, A, B, input Q, R, DZ, busy, done);
    modport slave  (input E, start, A, B, output Q, R, DZ, busy, done);

endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted W+1-bit partial remainder.
//   rem_sh : shifted partial remainder (W+1 bits)
//   dvs    : divisor (W bits)
//   rem_nx : difference when it does not underflow, otherwise rem_sh
//   q_bit  : quotient bit, the carry-out of rem_sh + ~{0,dvs} + 1
module div_step #(
    parameter int unsigned W = 8
) (
    input  logic [W:0]   rem_sh,
    input  logic [W-1:0] dvs,
    output logic [W:0]   rem_nx,
    output logic         q_bit
);
    localparam int unsigned SW = W + 2;

    logic [SW-1:0] sum;

    // Carry out of the W+1-bit add lands in the extra top bit.
    assign sum    = {1'b0, rem_sh} + {1'b0, ~{1'b0, dvs}} + SW'(1);
    assign q_bit  = sum[SW-1];
    assign rem_nx = q_bit ? sum[W:0] : rem_sh;

endmodule

// File: rtl/div_seq8.sv
// Sequential unsigned restoring divider with start/busy/done handshake and
// a stall enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of div_seq8_if (E, start, A, B in; Q, R, DZ,
//                busy, done out, all outputs registered)
module div_seq8
    import div_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    div_seq8_if.slave   bus
);
    localparam int unsigned CW = cnt_width(W);

    state_e        state_q, state_d;
    logic [W-1:0]  qsh_q, qsh_d;
    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [W:0]    rem_sh;
    logic [W:0]    rem_nx;
    logic          q_bit;
    logic [W-1:0]  qsh_nx;

    // Shift the next dividend bit into the partial remainder.
    assign rem_sh = {rem_q[W-1:0], qsh_q[W-1]};
    assign qsh_nx = {qsh_q[W-2:0], q_bit};

    div_step #(.W(W)) u_step (
        .rem_sh (rem_sh),
        .dvs    (dvs_q),
        .rem_nx (rem_nx),
        .q_bit  (q_bit)
    );

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        qsh_d   = qsh_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (bus.E && bus.start) begin
                    qsh_d = bus.A;
                    dvs_d = bus.B;
                    rem_d = '0;
                    cnt_d = CW'(W);
                    dz_d  = 1'b0;
                    if (bus.B == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = bus.A;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.E) begin
                    rem_d = rem_nx;
                    qsh_d = qsh_nx;
                    cnt_d = cnt_q - CW'(1);
                    // Last step: publish results as DONE is entered.
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        q_d     = qsh_nx;
                        r_d     = rem_nx[W-1:0];
                    end
                end
            end
            DONE: begin
                // Leaves unconditionally so the done pulse is never stretched.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC);
        done_d = (state_d == DONE);
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            qsh_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qsh_q   <= qsh_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.DZ   = dz_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_div_seq8.sv
// Scoreboard bench for div_seq8: stimulus pushes expected results, a
// negedge monitor pops and compares whenever done is high.
module tb_div_seq8;
    import div_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         edges;
        int         start_cyc;
        string      name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    div_seq8_if #(.W(W)) bus();

    div_seq8 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_seen++;
            check("done_pulse_len", {31'b0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got Q=%0d R=%0d, expected no result", bus.Q, bus.R);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_Q"},  32'(bus.Q),  32'(mon_e.q));
                check({mon_e.name, "_R"},  32'(bus.R),  32'(mon_e.r));
                check({mon_e.name, "_DZ"}, 32'(bus.DZ), 32'(mon_e.dz));
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.edges));
            end
        end
        prev_done = bus.done;
    end

    // Present an operation for one start edge; optionally record its expectation.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int edges, input string nm, input bit track);
        exp_t x;
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.E     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            x.q = eq; x.r = er; x.dz = edz; x.edges = edges;
            x.start_cyc = cyc; x.name = nm;
            sb.push_back(x);
        end
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = 8'h3C;
    endtask

    // Wait (bounded) for done, counting cycles with busy high on the way.
    task automatic wait_done(input string nm, input int exp_busy);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in 40 cycles, expected done", nm);
        end
        check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        bus.E = 1'b0; bus.start = 1'b0; bus.A = '0; bus.B = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_Q", 32'(bus.Q), 0);
        check("reset_R", 32'(bus.R), 0);
        check("reset_DZ", 32'(bus.DZ), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 50/7, results held afterwards
        issue(8'd50, 8'd7, 8'd7, 8'd1, 1'b0, 9, "t1", 1'b1);
        wait_done("t1", 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_hold_Q", 32'(bus.Q), 7);
            check("t1_hold_R", 32'(bus.R), 1);
        end

        // 2: 255/1 then 0/200
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, "t2a", 1'b1);
        wait_done("t2a", 8);
        issue(8'd0, 8'd200, 8'd0, 8'd0, 1'b0, 9, "t2b", 1'b1);
        wait_done("t2b", 8);

        // 3: divide by zero, then 9/3 clears DZ
        issue(8'd100, 8'd0, 8'd255, 8'd100, 1'b1, 1, "t3a", 1'b1);
        wait_done("t3a", 0);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 9, "t3b", 1'b1);
        wait_done("t3b", 8);

        // 4: 200/55 with a 3-cycle stall after three steps
        issue(8'd200, 8'd55, 8'd3, 8'd35, 1'b0, 12, "t4", 1'b1);
        repeat (3) @(posedge clk);
        #1 bus.E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_busy", 32'(bus.busy), 1);
            check("t4_stall_Q", 32'(bus.Q), 3);
            check("t4_stall_R", 32'(bus.R), 0);
            @(posedge clk);
        end
        #1 bus.E = 1'b1;
        wait_done("t4", 5);

        // 5: 127/128 with a second start during CALC that must be ignored
        issue(8'd127, 8'd128, 8'd0, 8'd127, 1'b0, 9, "t5", 1'b1);
        @(posedge clk);
        #1;
        bus.A = 8'd1; bus.B = 8'd1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("t5", 6);

        // 6: asynchronous reset mid-calculation, then 128/128
        issue(8'd255, 8'd255, 8'd0, 8'd0, 1'b0, 0, "t6a", 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_Q", 32'(bus.Q), 0);
        check("t6_rst_R", 32'(bus.R), 0);
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_done", 32'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t6_no_done_after_abort", 32'(done_seen), 7);
        issue(8'd128, 8'd128, 8'd1, 8'd0, 1'b0, 9, "t6b", 1'b1);
        wait_done("t6b", 8);

        repeat (3) @(negedge clk);
        check("done_count", 32'(done_seen), 8);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
